// File: rtl/frame_buf_pkg.sv
// Shared types and constants for the ping-pong frame buffer.
//   bank_state_t : lifecycle of one frame bank (FREE -> FILL -> FULL -> READ -> FREE)
//   NUM_BANKS    : number of frame banks (ping and pong)
//   SKID_DEPTH   : entries in the read-side output FIFO
package frame_buf_pkg;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    READ = 2'd3
  } bank_state_t;

  localparam int NUM_BANKS  = 2;
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/data_mem.sv
// Simple dual-port RAM with one write port and one registered read port.
//   clk           : clock
//   we/waddr/wdata: write port, written on the rising edge when we = 1
//   re/raddr      : read request; rdata is valid the cycle after re = 1
//   rdata         : registered read data
// Contents are never cleared.
module data_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buf_skid.sv
// Two-entry FIFO holding memory read data with its frame tags.
//   in_valid/in_sof/in_eof/in_data : push side; the producer never pushes
//                                    into a full FIFO (it reserves space
//                                    before issuing a memory read)
//   out_valid/out_ready            : pop side handshake
//   out_sof/out_eof/out_data       : head entry; tags are forced low when empty
//   count                          : current occupancy
// Handshake: a word transfers on a rising edge where valid && ready; while
// valid && !ready the head and its tags are held unchanged.
module frame_buf_skid
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic                  in_eof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);

  localparam int EW = DATA_WIDTH + 2;

  logic [EW-1:0] ent_q [SKID_DEPTH];
  logic          wr_idx_q;
  logic          rd_idx_q;
  logic [1:0]    count_q;
  logic          pop;
  logic [EW-1:0] head;

  assign pop       = out_valid && out_ready;
  assign out_valid = (count_q != 2'd0);
  assign head      = ent_q[rd_idx_q];
  assign out_data  = head[DATA_WIDTH-1:0];
  assign out_sof   = out_valid && head[EW-1];
  assign out_eof   = out_valid && head[EW-2];
  assign count     = count_q;

  // Payload storage carries no reset; entries are only observed when counted.
  always_ff @(posedge clk) begin
    if (in_valid) ent_q[wr_idx_q] <= {in_sof, in_eof, in_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (in_valid) wr_idx_q <= ~wr_idx_q;
      if (pop)      rd_idx_q <= ~rd_idx_q;
      case ({in_valid, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/frame_buf_pp.sv
// Double-buffered (ping-pong) frame buffer.
//   wr_valid/wr_ready/wr_data/wr_sof : producer stream; wr_sof restarts the
//                                      frame at word 0, dropping a partial one
//   rd_valid/rd_ready/rd_data        : consumer stream, one frame per bank
//   rd_sof/rd_eof                    : first / last word of a frame
//   frames_avail                     : banks holding a complete frame (FULL or READ)
// Handshake: both streams transfer a word on a rising edge where
// valid && ready; a stalled rd_valid keeps rd_data/rd_sof/rd_eof stable.
// The writer fills bank wb while the reader drains bank rb; a bank only
// becomes readable once all FRAME_WORDS words are written, so the reader
// never sees a partial frame.
module frame_buf_pp
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter bit REPEAT_EN  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_sof,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_sof,
  output logic                  rd_eof,
  output logic [1:0]            frames_avail
);

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = {ADDR_WIDTH{1'b1}};

  bank_state_t           bank_q [NUM_BANKS];
  logic                  wb_q;
  logic                  rb_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic                  rd_inflight_q;
  logic                  rd_sof_q;
  logic                  rd_eof_q;

  logic                  wr_acc;
  logic [ADDR_WIDTH-1:0] wr_word;
  logic                  wr_done;
  logic                  rd_bank_ok;
  logic [2:0]            rd_slots_used;
  logic                  rd_issue;
  logic                  rd_last;
  logic                  other_full;
  logic                  rd_release;
  logic                  skid_pop;
  logic [1:0]            skid_count;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // ---------------- write side ----------------
  assign wr_ready = (bank_q[wb_q] == FREE) || (bank_q[wb_q] == FILL);
  assign wr_acc   = wr_valid && wr_ready;
  assign wr_word  = wr_sof ? '0 : wr_ptr_q;
  assign wr_done  = wr_acc && (wr_word == LAST_WORD);

  // ---------------- read side ----------------
  assign skid_pop   = rd_valid && rd_ready;
  assign rd_bank_ok = (bank_q[rb_q] == FULL) || (bank_q[rb_q] == READ);
  // Space is reserved against the skid occupancy left after this cycle's pop
  // plus the word still coming out of the memory; this keeps one read per
  // cycle flowing with rd_ready held high while never overflowing the skid.
  assign rd_slots_used = {1'b0, skid_count} - {2'b00, skid_pop} + {2'b00, rd_inflight_q};
  assign rd_issue      = rd_bank_ok && (rd_slots_used < 3'(SKID_DEPTH));
  assign rd_last       = rd_issue && (rd_ptr_q == LAST_WORD);
  // A frame completing in the same cycle already counts as a newer frame.
  assign other_full    = (bank_q[~rb_q] == FULL) || (wr_done && (wb_q != rb_q));
  assign rd_release    = rd_last && (!REPEAT_EN || other_full);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BANKS; i++) bank_q[i] <= FREE;
      wb_q          <= 1'b0;
      rb_q          <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_inflight_q <= 1'b0;
      rd_sof_q      <= 1'b0;
      rd_eof_q      <= 1'b0;
    end else begin
      // Writer and reader never own the same bank at once (FREE/FILL vs
      // FULL/READ), so these two updates never target the same entry.
      if (wr_acc) begin
        if (wr_done) begin
          bank_q[wb_q] <= FULL;
          wb_q         <= ~wb_q;
          wr_ptr_q     <= '0;
        end else begin
          bank_q[wb_q] <= FILL;
          wr_ptr_q     <= wr_word + 1'b1;
        end
      end
      if (rd_issue) begin
        if (rd_last) begin
          rd_ptr_q <= '0;
          if (rd_release) begin
            bank_q[rb_q] <= FREE;
            rb_q         <= ~rb_q;
          end else begin
            // Repeat mode with nothing newer: re-arm the same frame.
            bank_q[rb_q] <= FULL;
          end
        end else begin
          bank_q[rb_q] <= READ;
          rd_ptr_q     <= rd_ptr_q + 1'b1;
        end
      end
      rd_inflight_q <= rd_issue;
      rd_sof_q      <= rd_issue && (rd_ptr_q == '0);
      rd_eof_q      <= rd_last;
    end
  end

  always_comb begin
    frames_avail = 2'd0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if ((bank_q[i] == FULL) || (bank_q[i] == READ)) frames_avail = frames_avail + 2'd1;
    end
  end

  data_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH + 1)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr ({wb_q, wr_word}),
    .wdata (wr_data),
    .re    (rd_issue),
    .raddr ({rb_q, rd_ptr_q}),
    .rdata (mem_rdata)
  );

  frame_buf_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_inflight_q),
    .in_sof    (rd_sof_q),
    .in_eof    (rd_eof_q),
    .in_data   (mem_rdata),
    .out_valid (rd_valid),
    .out_ready (rd_ready),
    .out_sof   (rd_sof),
    .out_eof   (rd_eof),
    .out_data  (rd_data),
    .count     (skid_count)
  );

endmodule
